// File: rtl/systolic_array_os_if.sv
// Tile handshake bundle for the output-stationary systolic array.
// slave = array side, master = driver/sink side.
interface systolic_array_os_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int K_MAX  = 64
) ();
    localparam int KW = $clog2(K_MAX + 1);

    logic                     start;
    logic [KW-1:0]            k_len;
    logic                     busy;
    logic                     done;
    logic                     in_valid;
    logic                     in_ready;
    logic [ROWS*DATA_W-1:0]   a_vec;
    logic [COLS*DATA_W-1:0]   b_vec;
    logic                     out_valid;
    logic                     out_ready;
    logic [ROWS*ACC_W-1:0]    out_data;

    modport slave (
        input  start, k_len, in_valid, a_vec, b_vec, out_ready,
        output busy, done, in_ready, out_valid, out_data
    );

    modport master (
        output start, k_len, in_valid, a_vec, b_vec, out_ready,
        input  busy, done, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS signed MAC array with input skew,
// k-length control FSM and column-by-column result drain.
module systolic_array_os #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int K_MAX  = 64
) (
    input  logic               clk,
    input  logic               rst,
    systolic_array_os_if.slave bus
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int FW = $clog2(ROWS + COLS);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d, cnt_q, cnt_d, cnt_inc;
    logic [FW-1:0] fl_q, fl_d;
    logic [CW-1:0] col_q, col_d;
    logic          done_q, done_d;
    logic          adv, clr, beat;

    logic signed [DATA_W-1:0] ask_q [ROWS][ROWS];
    logic signed [DATA_W-1:0] ask_d [ROWS][ROWS];
    logic signed [DATA_W-1:0] bsk_q [COLS][COLS];
    logic signed [DATA_W-1:0] bsk_d [COLS][COLS];
    logic signed [DATA_W-1:0] a_q   [ROWS][COLS];
    logic signed [DATA_W-1:0] a_d   [ROWS][COLS];
    logic signed [DATA_W-1:0] b_q   [ROWS][COLS];
    logic signed [DATA_W-1:0] b_d   [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc_q [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc_d [ROWS][COLS];
    logic signed [DATA_W-1:0] a_w   [ROWS][COLS];
    logic signed [DATA_W-1:0] b_n   [ROWS][COLS];
    logic signed [PW-1:0]     prod  [ROWS][COLS];
    logic signed [DATA_W-1:0] a_in  [ROWS];
    logic signed [DATA_W-1:0] b_in  [COLS];

    assign cnt_inc = cnt_q + KW'(1);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        fl_d    = fl_q;
        col_d   = col_q;
        done_d  = 1'b0;
        adv     = 1'b0;
        clr     = 1'b0;
        beat    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    k_d   = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
                    cnt_d = '0;
                    col_d = '0;
                    clr   = 1'b1;
                    state_d = (bus.k_len == '0) ? S_DRAIN : S_FEED;
                end
            end
            S_FEED: begin
                adv  = 1'b1;
                beat = bus.in_valid;
                if (bus.in_valid) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == k_q) begin
                        state_d = S_FLUSH;
                        fl_d    = '0;
                    end
                end
            end
            S_FLUSH: begin
                adv  = 1'b1;
                fl_d = fl_q + FW'(1);
                if (fl_q == FW'(ROWS + COLS - 2)) begin
                    state_d = S_DRAIN;
                    col_d   = '0;
                end
            end
            S_DRAIN: begin
                if (bus.out_ready) begin
                    if (col_q == CW'(COLS - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
        endcase
    end

    // Row 0 / column 0 see the slice directly; deeper lanes tap the skew chain.
    always_comb begin
        for (int i = 0; i < ROWS; i++)
            a_in[i] = beat ? $signed(bus.a_vec[i*DATA_W +: DATA_W]) : '0;
        for (int j = 0; j < COLS; j++)
            b_in[j] = beat ? $signed(bus.b_vec[j*DATA_W +: DATA_W]) : '0;
        a_w[0][0] = a_in[0];
        for (int i = 1; i < ROWS; i++)
            a_w[i][0] = ask_q[i][i-1];
        for (int i = 0; i < ROWS; i++)
            for (int j = 1; j < COLS; j++)
                a_w[i][j] = a_q[i][j-1];
        b_n[0][0] = b_in[0];
        for (int j = 1; j < COLS; j++)
            b_n[0][j] = bsk_q[j][j-1];
        for (int i = 1; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                b_n[i][j] = b_q[i-1][j];
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                prod[i][j] = PW'(a_w[i][j]) * PW'(b_n[i][j]);
    end

    always_comb begin
        ask_d = ask_q;
        bsk_d = bsk_q;
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clr) begin
            ask_d = '{default: '0};
            bsk_d = '{default: '0};
            a_d   = '{default: '0};
            b_d   = '{default: '0};
            acc_d = '{default: '0};
        end else if (adv) begin
            for (int i = 0; i < ROWS; i++) begin
                ask_d[i][0] = a_in[i];
                for (int s = 1; s < ROWS; s++)
                    ask_d[i][s] = ask_q[i][s-1];
            end
            for (int j = 0; j < COLS; j++) begin
                bsk_d[j][0] = b_in[j];
                for (int s = 1; s < COLS; s++)
                    bsk_d[j][s] = bsk_q[j][s-1];
            end
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_d[i][j]   = a_w[i][j];
                    b_d[i][j]   = b_n[i][j];
                    acc_d[i][j] = acc_q[i][j] + ACC_W'(prod[i][j]);
                end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            fl_q    <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
            ask_q   <= '{default: '0};
            bsk_q   <= '{default: '0};
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            acc_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            fl_q    <= fl_d;
            col_q   <= col_d;
            done_q  <= done_d;
            ask_q   <= ask_d;
            bsk_q   <= bsk_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.in_ready  = (state_q == S_FEED);
    assign bus.out_valid = (state_q == S_DRAIN);
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != S_IDLE) | done_q;

    always_comb begin
        bus.out_data = '0;
        if (state_q == S_DRAIN)
            for (int i = 0; i < ROWS; i++)
                bus.out_data[i*ACC_W +: ACC_W] = acc_q[i][col_q];
    end
endmodule
